display_loader: RTL and testbench
=================================

DISPLAY_LOADER -- requirements
Module: display_loader

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles the digit code is driven with latch low before latch rises.
REQ-002 SHALL have parameter HIGH_CYC, default 2: cycles latch is held high per digit.
REQ-003 SHALL have parameter BLANK_CODE, default 5'd31: code substituted for a blinked-off digit.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: load request; sampled every cycle.
REQ-007 SHALL have port digits_in, input, 30: six 5-bit codes; slot k = bits [5k+4:5k], slot 0 = display position 0.
REQ-008 SHALL have port blink_mask, input, 6: bit k set marks slot k as blinking.
REQ-009 SHALL have port blink_phase, input, 1: 1 = blinking slots are shown blank.
REQ-010 SHALL have port digit, output, 5: code presented to the display multiplexer shift input.
REQ-011 SHALL have port latch, output, 1: shift strobe; the multiplexer captures digit on the falling edge.
REQ-012 SHALL have port busy, output, 1: high while a load sequence is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse after the sixth digit is shifted.

Function
REQ-014 SHALL implement states IDLE, SETUP, HIGH, HOLD, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL capture the frame (digits_in with blink substitution) and enter SETUP for slot 5 on the next cycle.
REQ-016 Blink substitution SHALL replace slot k with BLANK_CODE when blink_mask[k]=1 and blink_phase=1, evaluated at capture only.
REQ-017 Slots SHALL be shifted in order 5,4,3,2,1,0, so that after six strobes slot k sits at display position k.
REQ-018 Per slot: SETUP for SETUP_CYC cycles (latch=0), then HIGH for HIGH_CYC cycles (latch=1), then HOLD for 1 cycle (latch=0, digit unchanged).
REQ-019 digit SHALL be stable from the first SETUP cycle through HOLD of the same slot.
REQ-020 After HOLD of slots 5..1, the block SHALL go to SETUP of the next lower slot; after HOLD of slot 0, it SHALL go to DONE.
REQ-021 With default parameters, each slot SHALL take 5 cycles and a frame 30 cycles; done SHALL assert on cycle 31 after the start-accept edge.
REQ-022 busy SHALL be 1 in SETUP, HIGH and HOLD, and 0 in IDLE and DONE.
REQ-023 done SHALL be 1 only in DONE, which lasts exactly one cycle; DONE SHALL go to IDLE unless a restart is due.
REQ-024 start=1 while busy SHALL set a pending flag and overwrite the pending frame; the latest request wins, and the frame in progress is not disturbed.
REQ-025 In DONE, if pending=1 or start=1, the block SHALL begin a new frame in SETUP of slot 5 on the next cycle and clear pending; start takes priority over the pending frame.
REQ-026 Slot index and phase counter SHALL wrap-free saturate: no slot below 0 is ever addressed; the phase counter width SHALL be clog2(max(SETUP_CYC,HIGH_CYC))+1.

Reset
REQ-027 rst=1 SHALL force IDLE, digit=0, latch=0, busy=0, done=0, pending=0, and clear captured frames.
REQ-028 rst asserted mid-frame SHALL abort the frame on the next edge with latch=0 and no further strobes; a partial frame in the multiplexer is accepted.
REQ-029 rst SHALL take priority over start in the same cycle.

Structure
REQ-030 Shared package display_pkg SHALL hold DIGIT_W=5, NUM_DIGITS=6, BLANK_CODE and the state enum, shared with the display multiplexer.
REQ-031 No sub-module; a single FSM with slot index and phase counter; instantiated beside the display multiplexer at top level.

Verification
REQ-032 Digits 1,2,3,4,5,6 (slot 0..5), defaults, start pulse -> latch falling edges at cycles 5,10,...,30 with digit 6,5,4,3,2,1; done at cycle 31; multiplexer model reads position k = k+1.
REQ-033 blink_mask=6'b000011, blink_phase=1 -> slots 0 and 1 shifted as 31; blink_phase=0 -> original codes.
REQ-034 Frame A, then start with frames B and C at cycles 8 and 12 -> A completes unchanged, C loads immediately after done, B is never shifted.
REQ-035 rst at cycle 13 of a frame -> latch=0 and busy=0 from the next edge, no more falling edges, done never pulses.
REQ-036 SETUP_CYC=1, HIGH_CYC=3 -> 5 cycles per slot, latch high exactly 3 cycles; start held high continuously -> back-to-back frames with one DONE cycle between them.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display loader and the display multiplexer:
// digit geometry, blank code, FSM states and frame helper functions.
package display_pkg;

  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 6;
  localparam int FRAME_W    = DIGIT_W * NUM_DIGITS;
  localparam int SLOT_W     = 3;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'd31;
  localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Blinking slots are replaced by the blank code only while the phase is "off".
  function automatic logic [FRAME_W-1:0] blink_frame(
    input logic [FRAME_W-1:0]    digits,
    input logic [NUM_DIGITS-1:0] mask,
    input logic                  phase,
    input logic [DIGIT_W-1:0]    blank
  );
    logic [FRAME_W-1:0] f;
    f = digits;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (mask[k] && phase) f[k*DIGIT_W +: DIGIT_W] = blank;
    end
    return f;
  endfunction

  function automatic logic [DIGIT_W-1:0] slot_code(
    input logic [FRAME_W-1:0] frame,
    input logic [SLOT_W-1:0]  slot
  );
    logic [DIGIT_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == SLOT_W'(i)) code = frame[i*DIGIT_W +: DIGIT_W];
    end
    return code;
  endfunction

endpackage

// File: rtl/display_loader.sv
// Serialises a six-digit frame into the display multiplexer, slot 5 first,
// with a setup / strobe-high / hold sequence per digit and one pending restart.
module display_loader
  import display_pkg::*;
#(
  parameter int                 SETUP_CYC  = 2,
  parameter int                 HIGH_CYC   = 2,
  parameter logic [DIGIT_W-1:0] BLANK_CODE = display_pkg::BLANK_CODE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_W-1:0]    digits_in,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic                  blink_phase,
  output logic [DIGIT_W-1:0]    digit,
  output logic                  latch,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  localparam int MAX_CYC = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int PW      = $clog2(MAX_CYC) + 1;

  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] HIGH_LAST  = PW'(HIGH_CYC - 1);

  state_e               state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]   pend_frame_q, pend_frame_d;
  logic                 pend_q, pend_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic [FRAME_W-1:0]   captured;
  logic                 busy_w;

  assign captured = blink_frame(digits_in, blink_mask, blink_phase, BLANK_CODE);
  assign busy_w   = (state_q == ST_SETUP) || (state_q == ST_HIGH) || (state_q == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      phase_q      <= '0;
      frame_q      <= '0;
      pend_frame_q <= '0;
      pend_q       <= 1'b0;
      digit_q      <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      phase_q      <= phase_d;
      frame_q      <= frame_d;
      pend_frame_q <= pend_frame_d;
      pend_q       <= pend_d;
      digit_q      <= digit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    phase_d      = phase_q;
    frame_d      = frame_q;
    pend_frame_d = pend_frame_q;
    pend_d       = pend_q;
    digit_d      = digit_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          frame_d = captured;
          slot_d  = LAST_SLOT;
          phase_d = '0;
          digit_d = slot_code(captured, LAST_SLOT);
        end
      end
      ST_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d = ST_HIGH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_HIGH: begin
        if (phase_q == HIGH_LAST) begin
          state_d = ST_HOLD;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_HOLD: begin
        // Slot 0 is the last one shifted; the index never goes below it.
        if (slot_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETUP;
          slot_d  = slot_q - SLOT_W'(1);
          phase_d = '0;
          digit_d = slot_code(frame_q, slot_q - SLOT_W'(1));
        end
      end
      ST_DONE: begin
        // A fresh request this cycle beats an older pending frame.
        if (start || pend_q) begin
          state_d = ST_SETUP;
          frame_d = start ? captured : pend_frame_q;
          slot_d  = LAST_SLOT;
          phase_d = '0;
          digit_d = slot_code(start ? captured : pend_frame_q, LAST_SLOT);
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (busy_w && start) begin
      pend_d       = 1'b1;
      pend_frame_d = captured;
    end
  end

  assign digit     = digit_q;
  assign latch     = (state_q == ST_HIGH);
  assign busy      = busy_w;
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_display_loader.sv
// Bench for display_loader: per-cycle strobe timing, strobe-order scoreboard
// and a display position model, for default and (1,3) timing parameters.
module tb_display_loader;
  import display_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic [29:0] digits_in = '0;
  logic [5:0]  blink_mask = '0;
  logic        blink_phase = 1'b0;

  logic [4:0] d1_digit, d2_digit;
  logic       d1_latch, d2_latch, d1_busy, d2_busy, d1_done, d2_done;
  logic [2:0] d1_state, d2_state;

  display_loader u_dut (
    .clk(clk), .rst(rst), .start(start1), .digits_in(digits_in),
    .blink_mask(blink_mask), .blink_phase(blink_phase),
    .digit(d1_digit), .latch(d1_latch), .busy(d1_busy), .done(d1_done),
    .state_dbg(d1_state)
  );

  display_loader #(.SETUP_CYC(1), .HIGH_CYC(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .digits_in(digits_in),
    .blink_mask(blink_mask), .blink_phase(blink_phase),
    .digit(d2_digit), .latch(d2_latch), .busy(d2_busy), .done(d2_done),
    .state_dbg(d2_state)
  );

  int sel = 0;
  logic [4:0] o_digit;
  logic       o_latch, o_busy, o_done;
  always_comb begin
    o_digit = (sel == 1) ? d2_digit : d1_digit;
    o_latch = (sel == 1) ? d2_latch : d1_latch;
    o_busy  = (sel == 1) ? d2_busy  : d1_busy;
    o_done  = (sel == 1) ? d2_done  : d1_done;
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];
  logic [4:0] cur_codes[6];
  logic [4:0] disp[6];
  logic       prev_latch = 1'b0;

  int          inj_c1 = -1, inj_c2 = -1;
  logic [29:0] inj_d1 = '0, inj_d2 = '0;
  bit          hold_start = 1'b0;
  bit          scramble = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference: slot k shows its code unless it blinks in the off phase
  function automatic logic [4:0] ref_code(input logic [29:0] d, input logic [5:0] m,
                                          input logic ph, input int k);
    logic [29:0] sh;
    if (m[k] && ph) return 5'd31;
    sh = d >> (5 * k);
    return sh[4:0];
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit v);
    if (sel == 1) start2 = v;
    else start1 = v;
  endtask

  task automatic load_expect(input logic [29:0] d, input logic [5:0] m, input logic ph);
    for (int k = 0; k < 6; k++) cur_codes[k] = ref_code(d, m, ph, k);
    exp_q.delete();
    for (int k = 5; k >= 0; k--) exp_q.push_back(cur_codes[k]);
    prev_latch = 1'b0;
  endtask

  task automatic accept(input logic [29:0] d, input logic [5:0] m, input logic ph);
    digits_in   = d;
    blink_mask  = m;
    blink_phase = ph;
    load_expect(d, m, ph);
    set_start(1'b1);
    tick();
    set_start(hold_start);
  endtask

  task automatic check_cycle(input int c, input int su, input int hi);
    int len, s, o;
    logic [4:0] e;
    len = su + hi + 1;
    if (c <= 6 * len) begin
      s = 5 - (c - 1) / len;
      o = (c - 1) % len;
      chk("busy", 32'(o_busy), 32'd1);
      chk("latch", 32'(o_latch), ((o >= su) && (o < su + hi)) ? 32'd1 : 32'd0);
      chk("done_early", 32'(o_done), 32'd0);
      chk("digit", 32'(o_digit), 32'(cur_codes[s]));
    end else begin
      chk("busy_at_done", 32'(o_busy), 32'd0);
      chk("latch_at_done", 32'(o_latch), 32'd0);
      chk("done", 32'(o_done), 32'd1);
    end
    if (prev_latch && !o_latch) begin
      chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("strobe_digit", 32'(o_digit), 32'(e));
      end
      for (int k = 5; k > 0; k--) disp[k] = disp[k-1];
      disp[0] = o_digit;
    end
    prev_latch = o_latch;
  endtask

  task automatic run_frame(input int su, input int hi);
    int last;
    bit sv;
    last = 6 * (su + hi + 1) + 1;
    for (int c = 1; c <= last; c++) begin
      check_cycle(c, su, hi);
      sv = hold_start;
      if (c == inj_c1) begin sv = 1'b1; digits_in = inj_d1; end
      if (c == inj_c2) begin sv = 1'b1; digits_in = inj_d2; end
      if (scramble) begin
        digits_in   = 30'($urandom);
        blink_mask  = 6'($urandom);
        blink_phase = 1'($urandom);
      end
      set_start(sv);
      if (c < last) tick();
    end
  endtask

  task automatic end_frame();
    chk("strobe_count", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 6; k++) chk("display_pos", 32'(disp[k]), 32'(cur_codes[k]));
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {29'd0, o_busy, o_latch, o_done}, 32'd0);
  endtask

  initial begin
    logic [29:0] fa, fb, fc, fy;
    for (int k = 0; k < 6; k++) disp[k] = '0;

    // reset, with start asserted alongside it
    rst = 1'b1; start1 = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      sel = i;
      chk("rst_digit", 32'(o_digit), 32'd0);
      check_idle("rst_flags");
    end
    sel = 0;
    start1 = 1'b0; rst = 1'b0;
    tick();
    check_idle("idle_after_rst");

    // digits 1..6 in slots 0..5
    accept({5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 6'b0, 1'b0);
    run_frame(2, 2);
    end_frame();
    tick();
    check_idle("idle_after_done");

    // blink substitution on slots 0 and 1, then the same frame unblinked
    accept({5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 6'b000011, 1'b1);
    run_frame(2, 2);
    end_frame();
    tick();
    accept({5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 6'b000011, 1'b0);
    run_frame(2, 2);
    end_frame();
    tick();

    // random frames; inputs scrambled mid-frame must not leak in
    scramble = 1'b1;
    for (int n = 0; n < 4; n++) begin
      accept(30'($urandom), 6'($urandom), 1'($urandom));
      run_frame(2, 2);
      end_frame();
      tick();
    end
    scramble = 1'b0;

    // requests while busy: latest wins and starts right after done
    fa = 30'($urandom); fb = 30'($urandom); fc = 30'($urandom);
    inj_c1 = 8;  inj_d1 = fb;
    inj_c2 = 12; inj_d2 = fc;
    accept(fa, 6'b0, 1'b0);
    run_frame(2, 2);
    end_frame();
    inj_c1 = -1; inj_c2 = -1;
    load_expect(fc, 6'b0, 1'b0);
    tick();
    run_frame(2, 2);
    end_frame();
    tick();
    check_idle("idle_after_pending");
    tick();
    check_idle("no_second_pending");

    // reset mid-frame at cycle 13
    accept(30'($urandom), 6'b0, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      check_cycle(c, 2, 2);
      if (c < 13) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort_flags");
    chk("abort_digit", 32'(o_digit), 32'd0);
    for (int c = 0; c < 40; c++) begin
      tick();
      check_idle("after_abort");
    end

    // SETUP_CYC=1, HIGH_CYC=3 with start held: back-to-back frames
    sel = 1;
    hold_start = 1'b1;
    fy = 30'($urandom);
    inj_c1 = 10; inj_d1 = fy;
    prev_latch = 1'b0;
    accept(30'($urandom), 6'b0, 1'b0);
    run_frame(1, 3);
    end_frame();
    hold_start = 1'b0;
    inj_c1 = -1;
    load_expect(fy, 6'b0, 1'b0);
    tick();
    run_frame(1, 3);
    end_frame();
    tick();
    check_idle("idle_after_b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
